// File: rtl/uart_tx_arb_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_if
//
// Bundles the requester-side handshake and the transmitter-side handshake of
// the shared UART TX arbiter.
//
//   req       requester -> arb   per-requester byte request (level)
//   req_data  requester -> arb   byte of requester i on bits [8i+7:8i]
//   req_lock  requester -> arb   keep grant for back-to-back bytes
//                                (exists only when UART_ARB_LOCK_EN is defined)
//   gnt       arb -> requester   one-hot, one-cycle "byte accepted" pulse
//   tx_start  arb -> TX          one-cycle start strobe
//   tx_data   arb -> TX          byte to transmit, held until the next issue
//   tx_busy   TX  -> arb         transmitter busy, start bit through stop bit
//   owner     arb -> observers   index of the requester currently/last served
//   arb_idle  arb -> observers   arbiter is in IDLE
//   err_to    arb -> observers   tx_busy never rose after tx_start
//
// Modports: master = the arbiter, slave = the requesters/transmitter side.
// Optional feature macro: UART_ARB_LOCK_EN.
// -----------------------------------------------------------------------------
interface uart_tx_arb_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
  logic [N_REQ-1:0]   req_lock;
`endif
  logic [N_REQ-1:0]   gnt;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic [IDX_W-1:0]   owner;
  logic               arb_idle;
  logic               err_to;

`ifdef UART_ARB_LOCK_EN
  modport master (
    input  req, req_data, req_lock, tx_busy,
    output gnt, tx_start, tx_data, owner, arb_idle, err_to
  );

  modport slave (
    output req, req_data, req_lock, tx_busy,
    input  gnt, tx_start, tx_data, owner, arb_idle, err_to
  );
`else
  modport master (
    input  req, req_data, tx_busy,
    output gnt, tx_start, tx_data, owner, arb_idle, err_to
  );

  modport slave (
    output req, req_data, tx_busy,
    input  gnt, tx_start, tx_data, owner, arb_idle, err_to
  );
`endif

endinterface

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//
// Round-robin arbiter sharing one UART transmitter among N_REQ byte
// requesters. One requester is selected per byte; its byte is latched and
// handed to the transmitter with a one-cycle start strobe, and the frame is
// tracked via tx_busy until it completes. If tx_busy does not rise within
// BUSY_TO cycles of the strobe, err_to pulses and the arbiter gives up on
// that byte (the requester was already granted and is not retried).
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   IDX_W    owner index width, ceil(log2(N_REQ))
//   BUSY_TO  cycles allowed between tx_start and tx_busy rising (1..255)
//
// Ports
//   sys_clk  system clock, single domain, rising edge
//   rst_n    synchronous active-low reset
//   bus      uart_tx_arb_if.master (req/req_data[/req_lock]/tx_busy in,
//            gnt/tx_start/tx_data/owner/arb_idle/err_to out)
//
// Optional feature macro: UART_ARB_LOCK_EN
//   defined   : a requester holding req_lock[owner] keeps the transmitter for
//               back-to-back bytes; the next byte issues straight from
//               WAIT_DONE, one cycle earlier than an unlocked issue.
//   undefined : every byte goes back through IDLE and round-robin.
// -----------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int BUSY_TO = 16
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  uart_tx_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Last counter value before giving up on tx_busy.
  localparam logic [7:0]       TO_LAST   = 8'(BUSY_TO - 1);
  // Pointer starts at the last requester so requester 0 is searched first.
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               tx_start_q, tx_start_d;
  logic               err_to_c;
  logic [IDX_W-1:0]   rr_win;

  // Round-robin pick: search ptr+1, ptr+2, ... modulo N_REQ. Walking the
  // search order backwards and overwriting leaves the first set bit in the
  // result. Only meaningful when at least one request bit is set.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [IDX_W-1:0] ptr,
    input logic [N_REQ-1:0] r
  );
    logic [IDX_W-1:0] win;
    int               idx;
    win = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (r[idx]) begin
        win = IDX_W'(idx);
      end
    end
    return win;
  endfunction

  // Byte slice of requester idx out of the packed request data bus.
  function automatic logic [7:0] byte_of(
    input logic [8*N_REQ-1:0] data,
    input logic [IDX_W-1:0]   idx
  );
    return data[8*int'(idx) +: 8];
  endfunction

  // One-hot grant vector for requester idx.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign rr_win = rr_pick(ptr_q, bus.req);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    gnt_d      = '0;
    tx_start_d = 1'b0;
    err_to_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A busy transmitter (e.g. still finishing a frame that was in
        // flight across a reset) blocks issue; no timeout runs here.
        if ((|bus.req) && !bus.tx_busy) begin
          ptr_d      = rr_win;
          owner_d    = rr_win;
          tx_data_d  = byte_of(bus.req_data, rr_win);
          gnt_d      = onehot(rr_win);
          tx_start_d = 1'b1;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        // err_to is decided in the same cycle the counter hits its limit so
        // the pulse lands exactly BUSY_TO cycles after tx_start.
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_to_c = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
`ifdef UART_ARB_LOCK_EN
          // Locked owner with another byte ready: reissue without passing
          // through IDLE, bypassing the round-robin search.
          if (bus.req[owner_q] && bus.req_lock[owner_q]) begin
            ptr_d      = owner_q;
            tx_data_d  = byte_of(bus.req_data, owner_q);
            gnt_d      = onehot(owner_q);
            tx_start_d = 1'b1;
            state_d    = ISSUE;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RESET;
      owner_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      gnt_q      <= gnt_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.owner    = owner_q;
  assign bus.arb_idle = (state_q == IDLE);
  assign bus.err_to   = err_to_c;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Directed bench for uart_tx_arb (N_REQ=4, IDX_W=2, BUSY_TO=16). A small TX
// model raises tx_busy the edge after it sees tx_start and holds it for
// BUSY_LEN cycles; ext_busy forces tx_busy high and model_en=0 makes the
// model ignore strobes. Inputs change and outputs are sampled 1 time unit
// after each rising edge. The lock scenario runs when UART_ARB_LOCK_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int BUSY_LEN = 10;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic model_en = 1'b1;
  logic ext_busy = 1'b0;
  int   mcnt     = 0;
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;

  uart_tx_arb_if #(.N_REQ(4), .IDX_W(2)) bus ();

  uart_tx_arb #(
    .N_REQ   (4),
    .IDX_W   (2),
    .BUSY_TO (16)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model.
  always @(posedge clk) begin
    if (bus.tx_start && model_en) mcnt <= BUSY_LEN;
    else if (mcnt != 0)           mcnt <= mcnt - 1;
  end

  assign bus.tx_busy = (mcnt != 0) || ext_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag, output int stamp);
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    if (bus.tx_start !== 1'b1) chk(tag, bus.tx_start, 1);
    stamp = cyc;
  endtask

  // Returns the cycle stamp of the first sample with tx_busy low after a
  // busy period.
  task automatic wait_busy_fall(input string tag, output int stamp);
    int n = 0;
    while (bus.tx_busy !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (bus.tx_busy !== 1'b1) chk({tag, "_rise"}, bus.tx_busy, 1);
    while (bus.tx_busy !== 1'b0 && n < 80) begin
      step();
      n++;
    end
    if (bus.tx_busy !== 1'b0) chk({tag, "_fall"}, bus.tx_busy, 0);
    stamp = cyc;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},      bus.gnt,      4'b0000);
    chk({tag, "_tx_start"}, bus.tx_start, 1'b0);
    chk({tag, "_tx_data"},  bus.tx_data,  8'h00);
    chk({tag, "_owner"},    bus.owner,    2'd0);
    chk({tag, "_arb_idle"}, bus.arb_idle, 1'b1);
    chk({tag, "_err_to"},   bus.err_to,   1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, m, n, starts;
    logic [3:0] eg;

    bus.req      = '0;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef UART_ARB_LOCK_EN
    bus.req_lock = '0;
`endif

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // ---------------- fairness: all four requesting ----------------
    bus.req = 4'b1111;
    m = 0;
    for (int k = 0; k < 5; k++) begin
      wait_start("fair_start", s);
      if (k > 0) chk("fair_gap", s - m, 2);
      eg = 4'b0001 << (k % 4);
      chk("fair_gnt",   bus.gnt,   eg);
      chk("fair_data",  bus.tx_data, 8'h10 + (k % 4));
      chk("fair_owner", bus.owner, k % 4);
      step();
      chk("fair_gnt_pulse", bus.gnt, 4'b0000);
      wait_busy_fall("fair_busy", m);
    end
    bus.req = '0;
    step();

    // ---------------- single requester ----------------
    bus.req_data[23:16] = 8'hA5;
    bus.req             = 4'b0100;
    step();
    chk("single_gnt",      bus.gnt,      4'b0100);
    chk("single_tx_start", bus.tx_start, 1'b1);
    chk("single_tx_data",  bus.tx_data,  8'hA5);
    chk("single_owner",    bus.owner,    2'd2);
    bus.req = '0;
    step();
    chk("single_start_pulse", bus.tx_start, 1'b0);
    wait_busy_fall("single_busy", m);
    chk("single_not_idle_yet", bus.arb_idle, 1'b0);
    step();
    chk("single_idle",      bus.arb_idle, 1'b1);
    chk("single_data_hold", bus.tx_data,  8'hA5);

    // ---------------- busy gating ----------------
    ext_busy           = 1'b1;
    bus.req_data[7:0]  = 8'h3C;
    bus.req            = 4'b0001;
    starts             = 0;
    repeat (6) begin
      step();
      if (bus.tx_start) starts++;
    end
    chk("gate_no_start", starts, 0);
    chk("gate_idle", bus.arb_idle, 1'b1);
    ext_busy = 1'b0;
    step();
    chk("gate_tx_start", bus.tx_start, 1'b1);
    chk("gate_gnt",      bus.gnt,      4'b0001);
    chk("gate_tx_data",  bus.tx_data,  8'h3C);
    bus.req = '0;
    wait_busy_fall("gate_busy", m);
    step();

    // ---------------- busy timeout ----------------
    model_en           = 1'b0;
    bus.req_data[15:8] = 8'h5A;
    bus.req            = 4'b0010;
    step();
    chk("to_tx_start", bus.tx_start, 1'b1);
    chk("to_tx_data",  bus.tx_data,  8'h5A);
    s       = cyc;
    bus.req = '0;
    n       = 0;
    while (bus.err_to !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("to_delay", cyc - s, 16);
    chk("to_not_idle_at_err", bus.arb_idle, 1'b0);
    step();
    chk("to_err_pulse", bus.err_to,   1'b0);
    chk("to_idle",      bus.arb_idle, 1'b1);
    model_en            = 1'b1;
    bus.req_data[31:24] = 8'h77;
    bus.req             = 4'b1000;
    step();
    chk("to_next_gnt",   bus.gnt,      4'b1000);
    chk("to_next_start", bus.tx_start, 1'b1);
    chk("to_next_data",  bus.tx_data,  8'h77);
    chk("to_next_owner", bus.owner,    2'd3);
    bus.req = '0;
    wait_busy_fall("to_next_busy", m);
    step();

    // ---------------- reset mid-frame ----------------
    bus.req_data[23:16] = 8'hC7;
    bus.req             = 4'b0100;
    wait_start("rmid_start", s);
    bus.req = '0;
    n = 0;
    while (bus.tx_busy !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    repeat (2) step();
    chk("rmid_in_frame", bus.arb_idle, 1'b0);
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req      = 4'b1111;
    rst_n        = 1'b0;
    step();
    chk_reset_vals("rmid");
    step();
    chk("rmid_hold_gnt",   bus.gnt,      4'b0000);
    chk("rmid_hold_start", bus.tx_start, 1'b0);
    rst_n = 1'b1;
    wait_start("rmid_first_start", s);
    chk("rmid_first_gnt",   bus.gnt,     4'b0001);
    chk("rmid_first_owner", bus.owner,   2'd0);
    chk("rmid_first_data",  bus.tx_data, 8'h10);
    bus.req = '0;
    wait_busy_fall("rmid_busy", m);
    step();

`ifdef UART_ARB_LOCK_EN
    // ---------------- lock: requester 1 sends three bytes ----------------
    bus.req_data[15:8]  = 8'hB1;
    bus.req_data[31:24] = 8'hD3;
    bus.req_lock        = 4'b0010;
    bus.req             = 4'b1010;
    wait_start("lk_start1", s);
    chk("lk_owner1", bus.owner,   2'd1);
    chk("lk_data1",  bus.tx_data, 8'hB1);
    bus.req_data[15:8] = 8'hB2;
    wait_busy_fall("lk_busy1", m);
    step();
    chk("lk_start2", bus.tx_start, 1'b1);
    chk("lk_gnt2",   bus.gnt,      4'b0010);
    chk("lk_data2",  bus.tx_data,  8'hB2);
    bus.req_data[15:8] = 8'hB3;
    wait_busy_fall("lk_busy2", m);
    step();
    chk("lk_start3", bus.tx_start, 1'b1);
    chk("lk_data3",  bus.tx_data,  8'hB3);
    chk("lk_owner3", bus.owner,    2'd1);
    bus.req      = 4'b1000;
    bus.req_lock = 4'b0000;
    wait_busy_fall("lk_busy3", m);
    step();
    chk("lk_gap_start", bus.tx_start, 1'b0);
    chk("lk_gap_idle",  bus.arb_idle, 1'b1);
    step();
    chk("lk_other_start", bus.tx_start, 1'b1);
    chk("lk_other_gnt",   bus.gnt,      4'b1000);
    chk("lk_other_owner", bus.owner,    2'd3);
    chk("lk_other_data",  bus.tx_data,  8'hD3);
    bus.req = '0;
    wait_busy_fall("lk_busy4", m);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
